ascon_hash_serdes: RTL

//  Parametrised serial load/unload front end for the masked Ascon hash core.

---
 rtl/ascon_pkg.sv | 27 ++
 rtl/ascon_shift_in.sv | 47 ++++
 rtl/ascon_hash_serdes.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// +----------------------------------------------------------------------------+
// | ascon_pkg: shared defaults and FSM state encoding for the Ascon serdes.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ascon_pkg;

  localparam int ASCON_Y = 40;
  localparam int ASCON_L = 256;
  localparam int WORD_W  = 64;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ARMED  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_shift_in.sv
// +----------------------------------------------------------------------------+
// | ascon_shift_in: SW-bit MSB-first shift register that ignores beats past    |
// | its own length. Revision: 1.0                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ascon_shift_in
  import ascon_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SW    = 1,
  parameter int CW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CW-1:0]    idx,
  input  logic [SW-1:0]    din,
  output logic [WIDTH-1:0] q
);

  localparam logic [CW-1:0] LIMIT = CW'(WIDTH / SW);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] nxt;

  generate
    if (WIDTH == SW) begin : g_whole
      assign nxt = din;
    end else begin : g_shift
      assign nxt = {sreg[WIDTH-SW-1:0], din};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (en && (idx < LIMIT)) begin
      sreg <= nxt;
    end
  end

  assign q = sreg;

endmodule

`default_nettype wire

// File: rtl/ascon_hash_serdes.sv
// +----------------------------------------------------------------------------+
// | ascon_hash_serdes: handshaked serial load / digest unload front end for    |
// | the masked Ascon hash core. Revision: 1.0                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ascon_hash_serdes
  import ascon_pkg::*;
#(
  parameter int Y  = ASCON_Y,
  parameter int L  = ASCON_L,
  parameter int D  = 3,
  parameter int NR = 7,
  parameter int SW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [D*SW-1:0] msg_shr,
  input  logic [NR*SW-1:0] rnd,
  input  logic [SW-1:0]   flt,
  input  logic            start,
  input  logic            abort,
  output logic            core_start,
  output logic [D*Y-1:0]  core_msg,
  output logic [NR*64-1:0] core_rnd,
  output logic [L-1:0]    core_flt,
  input  logic            core_done,
  input  logic [L-1:0]    core_hash,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int NB    = max3(Y, WORD_W, L) / SW;
  localparam int NO    = L / SW;
  localparam int CNT_W = $clog2(NB + 1);
  localparam int OUT_W = $clog2(NO + 1);
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(NB - 1);
  localparam logic [OUT_W-1:0] LAST_OUT = OUT_W'(NO - 1);

  generate
    if ((Y % SW != 0) || (L % SW != 0) || (WORD_W % SW != 0)) begin : g_bad_sw
      $error("ascon_hash_serdes: SW must divide Y, L and 64");
    end
  endgenerate

  logic [2:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic [L-1:0]     digest;
  logic             beat_acc;

  assign in_ready  = (state == S_LOAD);
  assign beat_acc  = in_valid && in_ready && !abort;
  assign out_valid = (state == S_UNLOAD);
  assign out_last  = out_valid && (out_cnt == LAST_OUT);
  assign busy      = (state != S_IDLE);
  // Digest shifts right on each accepted beat, so bit 0 is always the current beat.
  assign out_data  = digest[SW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      out_cnt    <= '0;
      digest     <= '0;
      core_start <= 1'b0;
    end else begin
      core_start <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        beat_cnt <= '0;
        out_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_LOAD;
            beat_cnt <= '0;
            out_cnt  <= '0;
          end
          S_LOAD: begin
            if (beat_acc) begin
              beat_cnt <= beat_cnt + 1'b1;
              if (beat_cnt == LAST_IN) state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (start) begin
              core_start <= 1'b1;
              state      <= S_RUN;
            end
          end
          S_RUN: begin
            if (core_done) begin
              digest <= core_hash;
              state  <= S_UNLOAD;
            end
          end
          S_UNLOAD: begin
            if (out_ready) begin
              digest  <= digest >> SW;
              out_cnt <= out_cnt + 1'b1;
              if (out_cnt == LAST_OUT) state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar k = 0; k < D; k++) begin : g_share
      ascon_shift_in #(.WIDTH(Y), .SW(SW), .CW(CNT_W)) u_shr (
        .clk (clk),
        .rst (rst),
        .en  (beat_acc),
        .idx (beat_cnt),
        .din (msg_shr[k*SW +: SW]),
        .q   (core_msg[k*Y +: Y])
      );
    end
    for (genvar k = 0; k < NR; k++) begin : g_rnd
      ascon_shift_in #(.WIDTH(WORD_W), .SW(SW), .CW(CNT_W)) u_rnd (
        .clk (clk),
        .rst (rst),
        .en  (beat_acc),
        .idx (beat_cnt),
        .din (rnd[k*SW +: SW]),
        .q   (core_rnd[k*64 +: 64])
      );
    end
  endgenerate

  ascon_shift_in #(.WIDTH(L), .SW(SW), .CW(CNT_W)) u_flt (
    .clk (clk),
    .rst (rst),
    .en  (beat_acc),
    .idx (beat_cnt),
    .din (flt),
    .q   (core_flt)
  );

endmodule

`default_nettype wire
